// File: rtl/spi_slave_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared constants, FSM state type and edge helper for the SPI target.
// Revision : 1.0  initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_W = 8;

    // Mode 0: sample MOSI on the rising SCK edge, launch MISO on the falling one.
    localparam bit SAMPLE_ON_RISE = 1'b1;
    localparam bit SHIFT_ON_FALL  = 1'b1;

    typedef enum logic [1:0] {
        WAIT_DESEL = 2'd0,
        IDLE       = 2'd1,
        LOAD       = 2'd2,
        SHIFT      = 2'd3
    } spis_state_t;

    function automatic logic edge_up(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_controller_if
// Brief    : CPU strobe/status bus plus SPI pad signals of the SPI target.
// Revision : 1.0  initial release
// ============================================================================
interface spi_slave_controller_if;
    import spi_pkg::*;

    logic             wr;
    logic [SPI_W-1:0] din;
    logic             rd;
    logic [SPI_W-1:0] dout;
    logic             data_avail;
    logic             rx_full;
    logic             tx_empty;
    logic             tx_full;
    logic             overrun;
    logic             underrun;
    logic             clr_err;
    logic             busy;
    logic             spi_cs;
    logic             spi_sck;
    logic             spi_mosi;
    logic             spi_miso;
    logic             spi_miso_oe;

    modport slave (
        input  wr, din, rd, clr_err, spi_cs, spi_sck, spi_mosi,
        output dout, data_avail, rx_full, tx_empty, tx_full,
               overrun, underrun, busy, spi_miso, spi_miso_oe
    );

    modport master (
        output wr, din, rd, clr_err, spi_cs, spi_sck, spi_mosi,
        input  dout, data_avail, rx_full, tx_empty, tx_full,
               overrun, underrun, busy, spi_miso, spi_miso_oe
    );

endinterface
`default_nettype wire

// File: rtl/gh_fifo_sync_sr.sv
`default_nettype none
// ============================================================================
// Module   : gh_fifo_sync_sr
// Brief    : Single-clock show-ahead FIFO; push on full and pop on empty are ignored.
// Revision : 1.0  initial release
// ============================================================================
module gh_fifo_sync_sr #(
    parameter int add_width  = 4,
    parameter int data_width = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  wr,
    input  wire logic                  rd,
    input  wire logic [data_width-1:0] d,
    output logic      [data_width-1:0] q,
    output logic                       empty,
    output logic                       full
);

    localparam int c_DEPTH = 2 ** add_width;

    logic [data_width-1:0] r_mem [c_DEPTH];
    logic [add_width:0]    r_wptr;
    logic [add_width:0]    r_rptr;
    logic                  w_wr_en;
    logic                  w_rd_en;

    assign w_wr_en = wr & ~full;
    assign w_rd_en = rd & ~empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[add_width] != r_rptr[add_width]) &&
                   (r_wptr[add_width-1:0] == r_rptr[add_width-1:0]);
    assign q     = r_mem[r_rptr[add_width-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) r_wptr <= r_wptr + 1'b1;
            if (w_rd_en) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wptr[add_width-1:0]] <= d;
    end

endmodule
`default_nettype wire

// File: rtl/spi_slave_controller_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_shifter
// Brief    : Pin synchronizers, SCK/CS edge detect, framing FSM and shift registers.
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter logic [SPI_W-1:0] FILL_BYTE   = 8'hFF,
    parameter int               SYNC_STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             spi_cs,
    input  wire logic             spi_sck,
    input  wire logic             spi_mosi,
    input  wire logic             tx_avail,
    input  wire logic [SPI_W-1:0] tx_byte,
    output logic                  tx_pop,
    output logic      [SPI_W-1:0] rx_byte,
    output logic                  rx_valid,
    output logic                  underrun_evt,
    output logic                  busy,
    output logic                  spi_miso,
    output logic                  spi_miso_oe
);

    localparam int          c_CNT_W         = $clog2(SPI_W);
    localparam logic [1:0]  c_ST_WAIT_DESEL = WAIT_DESEL;
    localparam logic [1:0]  c_ST_IDLE       = IDLE;
    localparam logic [1:0]  c_ST_LOAD       = LOAD;
    localparam logic [1:0]  c_ST_SHIFT      = SHIFT;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [SPI_W-1:0]       r_rx_sh;
    logic [SPI_W-1:0]       r_tx_sh;
    logic [SPI_W-1:0]       r_rx_byte;
    logic                   r_rx_valid;
    logic                   r_miso;
    logic                   r_miso_oe;

    logic w_sck_s, w_cs_s, w_mosi_s;
    logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
    logic w_sample, w_launch;
    logic w_reload;
    logic [SPI_W-1:0] w_load_byte;

    // CS sync chain resets to "selected" so a frame already in progress is
    // never mistaken for a fresh select after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0],  spi_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sck_d     <= w_sck_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = edge_up(w_sck_s, r_sck_d);
    assign w_sck_fall = edge_up(r_sck_d, w_sck_s);
    assign w_cs_rise  = edge_up(w_cs_s, r_cs_d);
    assign w_cs_fall  = edge_up(r_cs_d, w_cs_s);
    assign w_sample   = SAMPLE_ON_RISE ? w_sck_rise : w_sck_fall;
    assign w_launch   = SHIFT_ON_FALL  ? w_sck_fall : w_sck_rise;

    // A new TX byte is taken at frame start and at every byte boundary.
    assign w_reload     = ~w_cs_rise &
                          ((r_state == c_ST_LOAD) ||
                           ((r_state == c_ST_SHIFT) && ~w_sample && w_launch && (r_bit_cnt == '0)));
    assign w_load_byte  = tx_avail ? tx_byte : FILL_BYTE;
    assign tx_pop       = w_reload & tx_avail;
    assign underrun_evt = w_reload & ~tx_avail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_WAIT_DESEL;
            r_bit_cnt  <= '0;
            r_rx_sh    <= '0;
            r_tx_sh    <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_cs_rise && (r_state != c_ST_WAIT_DESEL)) begin
                r_state   <= c_ST_IDLE;
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_WAIT_DESEL: begin
                        if (w_cs_s) r_state <= c_ST_IDLE;
                    end
                    c_ST_IDLE: begin
                        if (w_cs_fall) r_state <= c_ST_LOAD;
                    end
                    c_ST_LOAD: begin
                        r_tx_sh   <= w_load_byte;
                        r_miso    <= w_load_byte[SPI_W-1];
                        r_miso_oe <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= c_ST_SHIFT;
                    end
                    c_ST_SHIFT: begin
                        if (w_sample) begin
                            r_rx_sh   <= {r_rx_sh[SPI_W-2:0], w_mosi_s};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_CNT_W'(SPI_W - 1)) begin
                                r_rx_byte  <= {r_rx_sh[SPI_W-2:0], w_mosi_s};
                                r_rx_valid <= 1'b1;
                            end
                        end else if (w_launch) begin
                            if (r_bit_cnt == '0) begin
                                r_tx_sh <= w_load_byte;
                                r_miso  <= w_load_byte[SPI_W-1];
                            end else begin
                                r_tx_sh <= {r_tx_sh[SPI_W-2:0], 1'b0};
                                r_miso  <= r_tx_sh[SPI_W-2];
                            end
                        end
                    end
                    default: r_state <= c_ST_WAIT_DESEL;
                endcase
            end
        end
    end

    assign rx_byte     = r_rx_byte;
    assign rx_valid    = r_rx_valid;
    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign busy        = ~w_cs_s & ((r_state == c_ST_LOAD) || (r_state == c_ST_SHIFT));

endmodule
`default_nettype wire

// File: rtl/spi_slave_controller.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_controller
// Brief    : SPI mode-0 target with 16-deep RX/TX FIFOs and sticky error flags.
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_controller
    import spi_pkg::*;
#(
    parameter int               FIFO_AW     = 4,
    parameter logic [SPI_W-1:0] FILL_BYTE   = 8'hFF,
    parameter int               SYNC_STAGES = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    spi_slave_controller_if.slave   bus
);

    logic             w_rx_valid;
    logic [SPI_W-1:0] w_rx_byte;
    logic             w_rx_empty;
    logic             w_rx_full;
    logic [SPI_W-1:0] w_rx_q;
    logic             w_tx_pop;
    logic [SPI_W-1:0] w_tx_q;
    logic             w_tx_empty;
    logic             w_tx_full;
    logic             w_underrun_evt;
    logic             w_overrun_evt;
    logic             w_rd_ok;

    logic [SPI_W-1:0] r_dout;
    logic             r_overrun;
    logic             r_underrun;

    spi_slave_shifter #(
        .FILL_BYTE   (FILL_BYTE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shifter (
        .clk          (clk),
        .rst          (rst),
        .spi_cs       (bus.spi_cs),
        .spi_sck      (bus.spi_sck),
        .spi_mosi     (bus.spi_mosi),
        .tx_avail     (~w_tx_empty),
        .tx_byte      (w_tx_q),
        .tx_pop       (w_tx_pop),
        .rx_byte      (w_rx_byte),
        .rx_valid     (w_rx_valid),
        .underrun_evt (w_underrun_evt),
        .busy         (bus.busy),
        .spi_miso     (bus.spi_miso),
        .spi_miso_oe  (bus.spi_miso_oe)
    );

    gh_fifo_sync_sr #(
        .add_width  (FIFO_AW),
        .data_width (SPI_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (w_rx_valid),
        .rd    (bus.rd),
        .d     (w_rx_byte),
        .q     (w_rx_q),
        .empty (w_rx_empty),
        .full  (w_rx_full)
    );

    gh_fifo_sync_sr #(
        .add_width  (FIFO_AW),
        .data_width (SPI_W)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (bus.wr),
        .rd    (w_tx_pop),
        .d     (bus.din),
        .q     (w_tx_q),
        .empty (w_tx_empty),
        .full  (w_tx_full)
    );

    // A byte arriving on a full RX FIFO is dropped even if a pop lands the same clk.
    assign w_overrun_evt = w_rx_valid & w_rx_full;
    assign w_rd_ok       = bus.rd & ~w_rx_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout     <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_rd_ok) r_dout <= w_rx_q;
            if (w_overrun_evt)     r_overrun <= 1'b1;
            else if (bus.clr_err)  r_overrun <= 1'b0;
            if (w_underrun_evt)    r_underrun <= 1'b1;
            else if (bus.clr_err)  r_underrun <= 1'b0;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.data_avail = ~w_rx_empty;
    assign bus.rx_full    = w_rx_full;
    assign bus.tx_empty   = w_tx_empty;
    assign bus.tx_full    = w_tx_full;
    assign bus.overrun    = r_overrun;
    assign bus.underrun   = r_underrun;

endmodule
`default_nettype wire
